// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end: FSM states, queue entry, helpers.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

   localparam int XLEN = 32;
   localparam logic [XLEN-1:0] DEFAULT_RESET_PC = 32'h0000_0000;

   // S_REQ : may issue a request
   // S_WAIT: one request accepted, its response still owed
   // S_DROP: a redirect landed while waiting; the owed response gets thrown away
   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_DROP = 2'd2
   } fetchState_t;

   typedef struct packed {
      logic [XLEN-1:0] instr;
      logic [XLEN-1:0] pc4;
   } fetchEntry_t;

   // Fetch addresses are always word aligned; the low two bits are discarded.
   function automatic logic [XLEN-1:0] wordAlign(input logic [XLEN-1:0] addr);
      return {addr[XLEN-1:2], 2'b00};
   endfunction

endpackage

// File: rtl/fetch_prefetch_unit_if.sv
// Bundles the instruction-memory, decode and redirect handshakes of the fetch unit.
// Latency: n/a (wires only).
// Backpressure: imem_ack throttles requests, id_ready throttles the decode side.
//
// master : the fetch unit (drives imem_req/imem_addr and the id_* outputs)
// slave  : the surroundings (memory, decode stage, EX redirect source)
interface fetch_prefetch_unit_if;
   import fetch_pkg::*;

   logic            imem_req;
   logic [XLEN-1:0] imem_addr;
   logic            imem_ack;
   logic            imem_rvalid;
   logic [XLEN-1:0] imem_rdata;

   logic            id_valid;
   logic [XLEN-1:0] id_instr;
   logic [XLEN-1:0] id_pc4;
   logic            id_ready;

   logic            redirect;
   logic [XLEN-1:0] redirect_pc;

   modport master (
      output imem_req, imem_addr, id_valid, id_instr, id_pc4,
      input  imem_ack, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
   );

   modport slave (
      input  imem_req, imem_addr, id_valid, id_instr, id_pc4,
      output imem_ack, imem_rvalid, imem_rdata, id_ready, redirect, redirect_pc
   );

endinterface

// File: rtl/fetch_fifo.sv
// Prefetch queue: DEPTH entries of {instr, pc4}, synchronous push/pop plus a flush.
// Latency: a pushed entry is visible at the head the cycle after the push (no bypass).
// Backpressure: push while full and pop while empty are ignored; caller reads count.
//
// Ports: clk, reset (async, active-high); push/pushData in; pop in; clear in
//        (wins over push and pop); headData/count/empty out.
module fetch_fifo
   import fetch_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     push,
   input  fetchEntry_t              pushData,
   input  logic                     pop,
   input  logic                     clear,
   output fetchEntry_t              headData,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
   localparam logic [AW:0] PTR_ONE  = {{AW{1'b0}}, 1'b1};

   fetchEntry_t mem [DEPTH];

   // One extra MSB on each pointer tells full from empty when the indices match.
   logic [AW:0] wrPtr;
   logic [AW:0] rdPtr;
   logic        full;
   logic        pushEn;
   logic        popEn;

   assign count  = wrPtr - rdPtr;
   assign empty  = (wrPtr == rdPtr);
   assign full   = (count == FULL_CNT);
   assign pushEn = push && !full;
   assign popEn  = pop && !empty;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else if (clear) begin
         wrPtr <= '0;
         rdPtr <= '0;
      end else begin
         if (pushEn) wrPtr <= wrPtr + PTR_ONE;
         if (popEn)  rdPtr <= rdPtr + PTR_ONE;
      end
   end

   // Storage is not reset; the head is only meaningful while !empty.
   always_ff @(posedge clk) begin
      if (pushEn && !clear) mem[wrPtr[AW-1:0]] <= pushData;
   end

   assign headData = mem[rdPtr[AW-1:0]];

endmodule

// File: rtl/fetch_prefetch_unit.sv
// Fetch front end: owns the PC, fetches words from imem, queues {instr, pc+4} for decode.
// Latency: 2 cycles imem_req -> id_valid with same-cycle ack and next-cycle rvalid.
// Backpressure: id_ready low holds the head; fetch stops once queue + outstanding = DEPTH.
//
// Ports: clk, reset (async, active-high); bus (fetch_prefetch_unit_if.master):
//        imem_req/imem_addr/imem_ack/imem_rvalid/imem_rdata toward memory,
//        id_valid/id_instr/id_pc4/id_ready toward decode, redirect/redirect_pc from EX.
module fetch_prefetch_unit
   import fetch_pkg::*;
#(
   parameter int              DEPTH    = 4,
   parameter logic [XLEN-1:0] RESET_PC = DEFAULT_RESET_PC
) (
   input  logic                  clk,
   input  logic                  reset,
   fetch_prefetch_unit_if.master bus
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

   fetchState_t     state;
   fetchState_t     stateNext;
   logic [XLEN-1:0] pc;
   logic [XLEN-1:0] pcNext;

   logic            reqInt;
   logic            push;
   logic            pop;
   logic            hasSpace;
   logic [CW-1:0]   count;
   logic            fifoEmpty;
   fetchEntry_t     head;
   fetchEntry_t     pushEntry;

   // Requests only issue from S_REQ, where nothing is outstanding, so comparing
   // the queue occupancy against DEPTH already accounts for the slot the next
   // response will need.
   assign hasSpace = (count < FULL_CNT);

   // A pop that coincides with a redirect is void: the flush wins.
   assign pop = !fifoEmpty && bus.id_ready && !bus.redirect;

   // pc was already advanced when the request was accepted, so it equals the
   // fetched address + 4 for the whole time the response is owed.
   assign pushEntry = '{instr: bus.imem_rdata, pc4: pc};

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state <= S_REQ;
         pc    <= wordAlign(RESET_PC);
      end else begin
         state <= stateNext;
         pc    <= pcNext;
      end
   end

   always_comb begin
      stateNext = state;
      pcNext    = pc;
      reqInt    = 1'b0;
      push      = 1'b0;

      unique case (state)
         S_REQ: begin
            // reset is gated in so the request stays low for as long as reset
            // is held, not just from the first clock edge onward.
            reqInt = !reset && !bus.redirect && hasSpace;
            if (bus.redirect) begin
               pcNext = wordAlign(bus.redirect_pc);
            end else if (reqInt && bus.imem_ack) begin
               pcNext    = pc + XLEN'(4);
               stateNext = S_WAIT;
            end
         end

         S_WAIT: begin
            if (bus.imem_rvalid) begin
               // Response arrives: keep it unless EX is redirecting this cycle.
               push      = !bus.redirect;
               stateNext = S_REQ;
               if (bus.redirect) pcNext = wordAlign(bus.redirect_pc);
            end else if (bus.redirect) begin
               // Response still owed but now stale; swallow it when it shows up.
               pcNext    = wordAlign(bus.redirect_pc);
               stateNext = S_DROP;
            end
         end

         S_DROP: begin
            if (bus.redirect) pcNext = wordAlign(bus.redirect_pc);
            if (bus.imem_rvalid) stateNext = S_REQ;
         end

         default: begin
            stateNext = S_REQ;
         end
      endcase
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) uFifo (
      .clk      (clk),
      .reset    (reset),
      .push     (push),
      .pushData (pushEntry),
      .pop      (pop),
      .clear    (bus.redirect),
      .headData (head),
      .count    (count),
      .empty    (fifoEmpty)
   );

   assign bus.imem_req  = reqInt;
   assign bus.imem_addr = pc;

   // Zero the head fields while invalid so decode never latches a stale word.
   assign bus.id_valid  = !fifoEmpty;
   assign bus.id_instr  = fifoEmpty ? '0 : head.instr;
   assign bus.id_pc4    = fifoEmpty ? '0 : head.pc4;

endmodule

// File: tb/tb_fetch_prefetch_unit.sv
// Self-checking bench for fetch_prefetch_unit: memory model + scoreboard of decode output.
// Latency: memory response latency is programmable per scenario.
// Backpressure: id_ready driven per scenario; imem_ack held high.
module tb_fetch_prefetch_unit;
   import fetch_pkg::*;

   localparam int          DEPTH  = 4;
   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic clk   = 1'b0;
   logic reset = 1'b1;

   fetch_prefetch_unit_if bus();

   fetch_prefetch_unit #(
      .DEPTH    (DEPTH),
      .RESET_PC (RST_PC)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus.master)
   );

   always #5 clk = ~clk;

   int tests = 0;
   int fails = 0;

   // memory / scoreboard model state
   fetchEntry_t expQ[$];
   logic [31:0] acceptLog[$];
   bit          ackOn = 1'b1;
   int          latency = 1;
   bit          pending = 1'b0;
   bit          dropFlag = 1'b0;
   logic [31:0] pendAddr = '0;
   int          waitCnt = 0;
   logic [31:0] modelPc = RST_PC;
   int          cycleNum = 0;
   int          popCount = 0;
   int          firstReq = -1;
   int          firstValid = -1;
   logic [31:0] firstPc4 = '0;

   function automatic logic [31:0] memData(input logic [31:0] a);
      return a ^ 32'h1357_9BDF;
   endfunction

   // One clock: called just after a falling edge with redirect/id_ready set.
   task automatic step();
      bit          rv;
      bit          wasPending;
      logic [31:0] rd;
      wasPending = pending;
      rv = pending && (waitCnt == 0);
      rd = rv ? memData(pendAddr) : 32'h0;
      bus.imem_rvalid = rv;
      bus.imem_rdata  = rd;
      bus.imem_ack    = ackOn;
      #1;
      // scoreboard: head of decode output
      tests++;
      if (bus.id_valid !== (expQ.size() != 0)) begin
         fails++;
         $display("FAIL sb_valid cyc=%0d got=%b want=%b", cycleNum, bus.id_valid, expQ.size() != 0);
      end else if (bus.id_valid === 1'b1) begin
         if (bus.id_instr !== expQ[0].instr || bus.id_pc4 !== expQ[0].pc4) begin
            fails++;
            $display("FAIL sb_head cyc=%0d got=%h/%h want=%h/%h", cycleNum,
                     bus.id_instr, bus.id_pc4, expQ[0].instr, expQ[0].pc4);
         end
      end else if (bus.id_instr !== 32'h0 || bus.id_pc4 !== 32'h0) begin
         fails++;
         $display("FAIL sb_idle_zero cyc=%0d got=%h/%h want=0/0", cycleNum, bus.id_instr, bus.id_pc4);
      end
      if (bus.id_valid === 1'b1 && firstValid < 0) begin
         firstValid = cycleNum;
         firstPc4   = bus.id_pc4;
      end
      // model the coming rising edge
      if (bus.id_valid === 1'b1 && bus.id_ready && !bus.redirect && expQ.size() != 0) begin
         void'(expQ.pop_front());
         popCount++;
      end
      if (bus.redirect) begin
         expQ.delete();
         modelPc = {bus.redirect_pc[31:2], 2'b00};
      end
      if (rv) begin
         if (!bus.redirect && !dropFlag)
            expQ.push_back('{instr: rd, pc4: pendAddr + 32'd4});
         pending  = 1'b0;
         dropFlag = 1'b0;
      end else if (bus.redirect && pending) begin
         dropFlag = 1'b1;
      end
      if (bus.imem_req === 1'b1 && ackOn) begin
         tests++;
         if (bus.imem_addr !== modelPc || wasPending) begin
            fails++;
            $display("FAIL req_addr cyc=%0d got=%h want=%h outstanding=%b", cycleNum,
                     bus.imem_addr, modelPc, wasPending);
         end
         pending  = 1'b1;
         pendAddr = bus.imem_addr;
         waitCnt  = latency - 1;
         modelPc  = bus.imem_addr + 32'd4;
         acceptLog.push_back(bus.imem_addr);
         if (firstReq < 0) firstReq = cycleNum;
      end else if (wasPending && !rv && waitCnt > 0) begin
         waitCnt--;
      end
      @(negedge clk);
      cycleNum++;
   endtask

   task automatic doReset();
      reset = 1'b1;
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.id_ready    = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      expQ.delete();
      acceptLog.delete();
      pending = 1'b0; dropFlag = 1'b0; waitCnt = 0;
      modelPc = RST_PC; firstReq = -1; firstValid = -1; popCount = 0;
      repeat (2) @(negedge clk);
      tests++;
      if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc4 !== 32'h0) begin
         fails++;
         $display("FAIL reset_outputs got req=%b vld=%b instr=%h pc4=%h want 0/0/0/0",
                  bus.imem_req, bus.id_valid, bus.id_instr, bus.id_pc4);
      end
      reset = 1'b0;
   endtask

   task automatic test_reset();
      doReset();
      #1;
      tests++;
      if (bus.imem_req !== 1'b1 || bus.imem_addr !== RST_PC) begin
         fails++;
         $display("FAIL reset_first_req got req=%b addr=%h want 1/%h", bus.imem_req, bus.imem_addr, RST_PC);
      end
      @(negedge clk);
   endtask

   task automatic test_stream();
      doReset();
      latency = 1; bus.id_ready = 1'b1;
      repeat (12) step();
      tests++;
      if (firstValid - firstReq != 2) begin
         fails++;
         $display("FAIL stream_latency got=%0d want=2", firstValid - firstReq);
      end
      tests++;
      if (firstPc4 !== 32'h4) begin
         fails++;
         $display("FAIL stream_first_pc4 got=%h want=4", firstPc4);
      end
      tests++;
      if (acceptLog.size() != 6 || acceptLog[5] !== 32'h14) begin
         fails++;
         $display("FAIL stream_reqs got n=%0d want n=6 last=0x14", acceptLog.size());
      end
   endtask

   task automatic test_backpressure();
      int p0;
      int n0;
      doReset();
      latency = 1; bus.id_ready = 1'b0;
      repeat (10) step();
      tests++;
      if (acceptLog.size() != DEPTH || bus.imem_req !== 1'b0) begin
         fails++;
         $display("FAIL bp_req_stop got n=%0d req=%b want n=%0d req=0", acceptLog.size(), bus.imem_req, DEPTH);
      end
      tests++;
      if (bus.id_valid !== 1'b1 || bus.id_instr !== memData(32'h0) || bus.id_pc4 !== 32'h4) begin
         fails++;
         $display("FAIL bp_head got vld=%b instr=%h pc4=%h want 1/%h/4", bus.id_valid, bus.id_instr,
                  bus.id_pc4, memData(32'h0));
      end
      p0 = popCount; n0 = acceptLog.size();
      bus.id_ready = 1'b1;
      repeat (4) step();
      tests++;
      if (popCount - p0 != 4) begin
         fails++;
         $display("FAIL bp_pops got=%0d want=4", popCount - p0);
      end
      repeat (2) step();
      tests++;
      if (acceptLog.size() <= n0 || acceptLog[n0] !== 32'h10) begin
         fails++;
         $display("FAIL bp_resume got n=%0d want first addr 0x10", acceptLog.size() - n0);
      end
   endtask

   task automatic test_redirect_wait();
      int          guard;
      int          n0;
      bit          seen;
      logic [31:0] dropped;
      doReset();
      latency = 3; bus.id_ready = 1'b1;
      guard = 0;
      while (!pending && guard < 5) begin step(); guard++; end
      tests++;
      if (!pending) begin
         fails++;
         $display("FAIL rw_no_request got pending=0 want 1");
      end
      dropped = pendAddr;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h40;
      step();
      bus.redirect = 1'b0;
      tests++;
      if (bus.id_valid !== 1'b0) begin
         fails++;
         $display("FAIL rw_valid_after got=%b want=0", bus.id_valid);
      end
      n0 = acceptLog.size(); seen = 1'b0;
      repeat (12) begin
         step();
         if (bus.id_valid === 1'b1 && bus.id_instr === memData(dropped)) seen = 1'b1;
      end
      tests++;
      if (seen) begin
         fails++;
         $display("FAIL rw_stale_data got=seen want=never (%h)", memData(dropped));
      end
      tests++;
      if (acceptLog.size() <= n0 || acceptLog[n0] !== 32'h40) begin
         fails++;
         $display("FAIL rw_next_addr got n=%0d want first addr 0x40", acceptLog.size() - n0);
      end
   endtask

   task automatic test_redirect_collision();
      int guard;
      int n0;
      doReset();
      latency = 1; bus.id_ready = 1'b0;
      guard = 0;
      while (!(pending && waitCnt == 0 && expQ.size() == 2) && guard < 20) begin step(); guard++; end
      tests++;
      if (guard >= 20) begin
         fails++;
         $display("FAIL rc_setup_timeout got qsize=%0d want 2", expQ.size());
      end
      bus.redirect = 1'b1; bus.redirect_pc = 32'h200; bus.id_ready = 1'b1;
      step();
      bus.redirect = 1'b0;
      tests++;
      if (bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0 || bus.id_pc4 !== 32'h0) begin
         fails++;
         $display("FAIL rc_flushed got vld=%b instr=%h pc4=%h want 0/0/0", bus.id_valid, bus.id_instr, bus.id_pc4);
      end
      n0 = acceptLog.size();
      repeat (3) step();
      tests++;
      if (acceptLog.size() <= n0 || acceptLog[n0] !== 32'h200) begin
         fails++;
         $display("FAIL rc_next_addr got n=%0d want first addr 0x200", acceptLog.size() - n0);
      end
   endtask

   task automatic test_align_wrap();
      int          n0;
      bit          seen;
      logic [31:0] wrapPc4;
      doReset();
      latency = 1; bus.id_ready = 1'b1;
      bus.redirect = 1'b1; bus.redirect_pc = 32'h103;
      step();
      bus.redirect = 1'b0;
      n0 = acceptLog.size();
      step();
      tests++;
      if (acceptLog.size() <= n0 || acceptLog[n0] !== 32'h100) begin
         fails++;
         $display("FAIL aw_align got n=%0d want addr 0x100", acceptLog.size() - n0);
      end
      repeat (2) step();
      bus.redirect = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
      step();
      bus.redirect = 1'b0;
      n0 = acceptLog.size(); seen = 1'b0; wrapPc4 = 32'hDEAD_BEEF;
      repeat (8) begin
         step();
         if (bus.id_valid === 1'b1 && bus.id_instr === memData(32'hFFFF_FFFC)) begin
            seen = 1'b1; wrapPc4 = bus.id_pc4;
         end
      end
      tests++;
      if (!seen || wrapPc4 !== 32'h0) begin
         fails++;
         $display("FAIL aw_pc4_wrap got seen=%b pc4=%h want 1/0", seen, wrapPc4);
      end
      tests++;
      if (acceptLog.size() < n0 + 2 || acceptLog[n0] !== 32'hFFFF_FFFC || acceptLog[n0+1] !== 32'h0) begin
         fails++;
         $display("FAIL aw_addr_wrap got n=%0d want FFFFFFFC then 0", acceptLog.size() - n0);
      end
   endtask

   task automatic test_reset_midflight();
      int guard;
      int n0;
      doReset();
      latency = 5; bus.id_ready = 1'b0;
      guard = 0;
      while (!(acceptLog.size() == DEPTH && pending) && guard < 40) begin step(); guard++; end
      tests++;
      if (guard >= 40 || bus.id_valid !== 1'b1) begin
         fails++;
         $display("FAIL rm_setup got n=%0d vld=%b want n=%0d vld=1", acceptLog.size(), bus.id_valid, DEPTH);
      end
      #2 reset = 1'b1;
      #1;
      tests++;
      if (bus.imem_req !== 1'b0 || bus.id_valid !== 1'b0 || bus.id_instr !== 32'h0) begin
         fails++;
         $display("FAIL rm_async got req=%b vld=%b instr=%h want 0/0/0", bus.imem_req, bus.id_valid, bus.id_instr);
      end
      doReset();
      latency = 1;
      n0 = acceptLog.size();
      repeat (2) step();
      tests++;
      if (acceptLog.size() <= n0 || acceptLog[n0] !== RST_PC) begin
         fails++;
         $display("FAIL rm_restart got n=%0d want first addr %h", acceptLog.size() - n0, RST_PC);
      end
   endtask

   initial begin
      bus.redirect    = 1'b0;
      bus.redirect_pc = 32'h0;
      bus.id_ready    = 1'b0;
      bus.imem_ack    = 1'b0;
      bus.imem_rvalid = 1'b0;
      bus.imem_rdata  = 32'h0;
      @(negedge clk);
      test_reset();
      test_stream();
      test_backpressure();
      test_redirect_wait();
      test_redirect_collision();
      test_align_wrap();
      test_reset_midflight();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog got=timeout want=finish");
      $fatal(1, "watchdog");
   end

endmodule
